dir_cmd_conditioner: RTL and testbench

//  Parametrised successor to the single-source direction debouncer: conditions N_SRC direction

---
 rtl/dir_cmd_conditioner_pkg.sv | 24 ++
 rtl/dir_cmd_conditioner_if.sv | 11 +
 rtl/dir_cmd_conditioner_chan_filter.sv | 52 +++++
 rtl/dir_cmd_conditioner.sv | 146 ++++++++++++++
 tb/tb_dir_cmd_conditioner.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dir_cmd_conditioner_pkg.sv
// Purpose : shared direction codes, FSM state encodings and small helpers for
//           the direction command conditioner.
// Contents: DIR_* codes, ST_* FSM states, dir_norm(), max_i().
package tfe_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Codes 5..7 carry no direction and are folded onto DIR_NONE.
  function automatic logic [2:0] dir_norm(input logic [2:0] d);
    return (d > DIR_NONE) ? DIR_NONE : d;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dir_cmd_conditioner_if.sv
// Purpose : valid/ready move-command channel.
// Signals : cmd_valid (master->slave), cmd_dir[2:0] (master->slave),
//           cmd_ready (slave->master).
interface dir_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_dir;

  modport master (output cmd_valid, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/dir_cmd_conditioner_chan_filter.sv
// Purpose : one direction source: 2-FF synchroniser followed by a stable-count
//           debounce. A code is accepted once it has held for STABLE_CYC
//           compare cycles after becoming the candidate.
// Ports   : clk, rst (async active-low), i_dir[2:0] (asynchronous source code),
//           o_stable[2:0] (debounced code, DIR_NONE after reset).
module dir_chan_filter
  import tfe_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_dir,
  output logic [2:0] o_stable
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYC - 1);

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_cand;
  logic [2:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_s;

  assign w_s      = dir_norm(r_sync2);
  assign o_stable = r_stable;

  // Synchroniser resets to DIR_NONE so a release never looks like an "up" press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= DIR_NONE;
      r_sync2  <= DIR_NONE;
      r_cand   <= DIR_NONE;
      r_stable <= DIR_NONE;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_dir;
      r_sync2 <= r_sync1;
      if (w_s != r_cand) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dir_cmd_conditioner.sv
// Purpose : conditions N_SRC direction sources into one move-command stream:
//           per-source debounce, fixed-priority merge (index 0 wins), one
//           command per press, optional auto-repeat, valid/ready output.
// Ports   : clk, rst (async active-low)
//           src_dir[3*N_SRC-1:0]  source i code at [3i+2:3i], asynchronous
//           src_en[N_SRC-1:0]     source participates in the merge
//           cmd (dir_cmd_if.master) cmd_valid / cmd_dir out, cmd_ready in
//           dir_level[2:0]        registered merged level (DIR_NONE = none)
//           cmd_drop              one-cycle pulse when a command event is lost
//
// FSM:
//   state   | meaning
//   IDLE    | no direction held; next non-none level issues a command
//   HOLD    | direction held; a new direction or repeat timeout issues
module dir_cmd_conditioner
  import tfe_pkg::*;
#(
  parameter int N_SRC      = 2,
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = 500000,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 20000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3*N_SRC-1:0] src_dir,
  input  logic [N_SRC-1:0]   src_en,
  dir_cmd_if.master          cmd,
  output logic [2:0]         dir_level,
  output logic               cmd_drop
);

  // Repeat timer is widened when needed so long repeat delays always fit.
  localparam int REP_W = max_i(CNT_W, max_i($clog2(REPEAT_DLY), $clog2(REPEAT_PER)) + 1);
  localparam logic [REP_W-1:0] DLY_TC = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] PER_TC = REP_W'(REPEAT_PER - 1);

  logic [2:0]       w_stable [N_SRC];
  logic [2:0]       w_merge;
  logic             w_issue;
  logic             w_rep_hit;

  logic [0:0]       r_state;
  logic [2:0]       r_level;
  logic [2:0]       r_held;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_first;
  logic             r_valid;
  logic [2:0]       r_dir;
  logic             r_drop;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_chan
      dir_chan_filter #(
        .CNT_W      (CNT_W),
        .STABLE_CYC (STABLE_CYC)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .i_dir    (src_dir[3*g +: 3]),
        .o_stable (w_stable[g])
      );
    end
  endgenerate

  // Walk from lowest priority upward so the lowest enabled index wins.
  always_comb begin
    w_merge = DIR_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_en[i] && (w_stable[i] != DIR_NONE)) w_merge = w_stable[i];
    end
  end

  assign w_rep_hit = (REPEAT_EN != 0) && (r_rep_cnt == (r_first ? DLY_TC : PER_TC));

  always_comb begin
    w_issue = 1'b0;
    if (r_level != DIR_NONE) begin
      if (r_state == ST_IDLE)      w_issue = 1'b1;
      else if (r_level != r_held)  w_issue = 1'b1;
      else if (w_rep_hit)          w_issue = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_level   <= DIR_NONE;
      r_held    <= DIR_NONE;
      r_rep_cnt <= '0;
      r_first   <= 1'b1;
      r_valid   <= 1'b0;
      r_dir     <= DIR_UP;
      r_drop    <= 1'b0;
    end else begin
      r_level <= w_merge;
      r_drop  <= 1'b0;

      // An accept frees the slot; an issue in the same cycle reloads it.
      if (r_valid && cmd.cmd_ready) r_valid <= 1'b0;
      if (w_issue) begin
        if (!r_valid || cmd.cmd_ready) begin
          r_valid <= 1'b1;
          r_dir   <= r_level;
        end else begin
          r_drop <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (r_level != DIR_NONE) begin
            r_state   <= ST_HOLD;
            r_held    <= r_level;
            r_rep_cnt <= '0;
            r_first   <= 1'b1;
          end
        end
        default: begin
          if (r_level == DIR_NONE) begin
            r_state <= ST_IDLE;
          end else if (r_level != r_held) begin
            r_held    <= r_level;
            r_rep_cnt <= '0;
            r_first   <= 1'b1;
          end else if (REPEAT_EN != 0) begin
            if (w_rep_hit) begin
              r_rep_cnt <= '0;
              r_first   <= 1'b0;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign cmd.cmd_valid = r_valid;
  assign cmd.cmd_dir   = r_dir;
  assign dir_level     = r_level;
  assign cmd_drop      = r_drop;

endmodule

// File: tb/tb_dir_cmd_conditioner.sv
// Bench for dir_cmd_conditioner: two instances (repeat off / repeat on) share
// the same stimulus. A run-length reference model predicts dir_level, command
// beats and drop pulses; a negedge monitor compares against it.
module tb_dir_cmd_conditioner;

  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] src_dir = 6'b100100;
  logic [1:0] src_en = 2'b11;
  logic       ready = 1'b1;

  dir_cmd_if bus0 ();
  dir_cmd_if bus1 ();
  assign bus0.cmd_ready = ready;
  assign bus1.cmd_ready = ready;

  logic [2:0] lvl0, lvl1;
  logic       drop0, drop1;

  dir_cmd_conditioner #(.N_SRC(2), .CNT_W(8), .STABLE_CYC(SC), .REPEAT_EN(0),
                        .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut0 (
    .clk(clk), .rst(rst), .src_dir(src_dir), .src_en(src_en),
    .cmd(bus0), .dir_level(lvl0), .cmd_drop(drop0));

  dir_cmd_conditioner #(.N_SRC(2), .CNT_W(8), .STABLE_CYC(SC), .REPEAT_EN(1),
                        .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut1 (
    .clk(clk), .rst(rst), .src_dir(src_dir), .src_en(src_en),
    .cmd(bus1), .dir_level(lvl1), .cmd_drop(drop1));

  always #5 clk = ~clk;

  logic       o_v [2];
  logic [2:0] o_d [2];
  logic       o_dr[2];
  assign o_v[0] = bus0.cmd_valid;  assign o_v[1] = bus1.cmd_valid;
  assign o_d[0] = bus0.cmd_dir;    assign o_d[1] = bus1.cmd_dir;
  assign o_dr[0] = drop0;          assign o_dr[1] = drop1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A source code is accepted once STABLE_CYC+1 consecutive clock samples agree;
  // the synchroniser adds two samples of delay, the merge one more register.
  logic [2:0] pipe [2][2];
  int         run_len [2];
  logic [2:0] run_val [2];
  logic [2:0] m_stable [2];
  logic [2:0] m_lvl = 3'd4;
  logic [2:0] m_lvl_prev = 3'd4;
  logic       m_valid [2];
  logic       m_drop [2];
  int         t_first [2];
  int         cyc = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         beats [2];
  int         drops [2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      pipe[s][0] = 3'd4; pipe[s][1] = 3'd4;
      run_val[s] = 3'd4; run_len[s] = 0; m_stable[s] = 3'd4;
      m_valid[s] = 1'b0; m_drop[s] = 1'b0; t_first[s] = 0;
    end
    m_lvl = 3'd4; m_lvl_prev = 3'd4;
    q0.delete(); q1.delete();
  endtask

  task automatic model_step();
    logic [2:0] lvl_old, new_lvl, v, x;
    int d;
    logic ev;
    lvl_old = m_lvl;
    new_lvl = 3'd4;
    for (int i = 1; i >= 0; i--)
      if (src_en[i] && m_stable[i] != 3'd4) new_lvl = m_stable[i];
    for (int u = 0; u < 2; u++) begin
      ev = 1'b0;
      if (lvl_old != 3'd4 && lvl_old != m_lvl_prev) begin
        ev = 1'b1; t_first[u] = cyc;
      end else if (u == 1 && lvl_old != 3'd4) begin
        d = cyc - t_first[u];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) ev = 1'b1;
      end
      m_drop[u] = 1'b0;
      if (ev && (!m_valid[u] || ready)) begin
        m_valid[u] = 1'b1;
        if (u == 0) q0.push_back(lvl_old); else q1.push_back(lvl_old);
      end else begin
        if (ev) m_drop[u] = 1'b1;
        if (m_valid[u] && ready) m_valid[u] = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      v = pipe[s][1];
      if (v == run_val[s]) run_len[s]++;
      else begin run_val[s] = v; run_len[s] = 1; end
      if (run_len[s] >= SC + 1) m_stable[s] = v;
      x = src_dir[3*s +: 3];
      if (x > 3'd4) x = 3'd4;
      pipe[s][1] = pipe[s][0];
      pipe[s][0] = x;
    end
    m_lvl_prev = lvl_old;
    m_lvl = new_lvl;
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset(); else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    beats[0] = 0; beats[1] = 0; drops[0] = 0; drops[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("dir_level0", int'(lvl0), int'(m_lvl));
        chk("dir_level1", int'(lvl1), int'(m_lvl));
        for (int u = 0; u < 2; u++) begin
          logic [2:0] exp;
          chk(u == 0 ? "cmd_valid0" : "cmd_valid1", int'(o_v[u]), int'(m_valid[u]));
          chk(u == 0 ? "cmd_drop0" : "cmd_drop1", int'(o_dr[u]), int'(m_drop[u]));
          if (o_dr[u]) drops[u]++;
          if (o_v[u]) begin
            if (u == 0) exp = (q0.size() > 0) ? q0[0] : 3'd7;
            else        exp = (q1.size() > 0) ? q1[0] : 3'd7;
            chk(u == 0 ? "cmd_dir0" : "cmd_dir1", int'(o_d[u]), int'(exp));
            if (ready) begin
              beats[u]++;
              if (u == 0 && q0.size() > 0) void'(q0.pop_front());
              if (u == 1 && q1.size() > 0) void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int s, input logic [2:0] v);
    src_dir[3*s +: 3] = v;
  endtask

  initial begin
    int b0, b1, dr0, hold;
    step(3);
    chk("rst_valid", int'(bus0.cmd_valid), 0);
    chk("rst_dir", int'(bus0.cmd_dir), 0);
    chk("rst_level", int'(lvl0), 4);
    chk("rst_drop", int'(drop0), 0);
    rst = 1'b1;
    step(5);

    // 1: single press, latency and one-cycle beat
    b0 = beats[0];
    set_src(0, 3'd1);
    step(7);
    chk("t1_level_early", int'(lvl0), 4);
    step(1);
    chk("t1_level", int'(lvl0), 1);
    step(1);
    chk("t1_valid_on", int'(bus0.cmd_valid), 1);
    step(1);
    chk("t1_valid_off", int'(bus0.cmd_valid), 0);
    step(10);
    set_src(0, 3'd4);
    step(25);
    chk("t1_beats", beats[0] - b0, 1);

    // 2: chatter never qualifies
    b0 = beats[0]; b1 = beats[1];
    for (int i = 0; i < 12; i++) begin
      set_src(0, (i % 2 == 0) ? 3'd1 : 3'd4);
      step(1);
    end
    set_src(0, 3'd4);
    step(20);
    chk("t2_beats0", beats[0] - b0, 0);
    chk("t2_beats1", beats[1] - b1, 0);

    // 3: auto-repeat at +0,+10,+15,...,+35 over a 40-cycle hold
    b1 = beats[1];
    set_src(0, 3'd2);
    step(40);
    set_src(0, 3'd4);
    step(30);
    chk("t3_repeat_beats", beats[1] - b1, 7);

    // 4: priority merge and src_en masking
    b0 = beats[0];
    set_src(1, 3'd3); step(15);
    set_src(0, 3'd0); step(15);
    set_src(0, 3'd4); step(20);
    set_src(1, 3'd4); step(20);
    chk("t4_beats", beats[0] - b0, 3);
    b0 = beats[0];
    src_en = 2'b01;
    set_src(1, 3'd3); step(20);
    set_src(1, 3'd4); step(15);
    src_en = 2'b11;
    step(5);
    chk("t4_masked_beats", beats[0] - b0, 0);

    // 5: back-pressure keeps the pending command, later event dropped
    b0 = beats[0]; dr0 = drops[0];
    ready = 1'b0;
    set_src(0, 3'd1); step(12);
    set_src(0, 3'd4); step(12);
    set_src(0, 3'd2); step(12);
    chk("t5_valid_held", int'(bus0.cmd_valid), 1);
    chk("t5_dir_held", int'(bus0.cmd_dir), 1);
    chk("t5_drops", drops[0] - dr0, 1);
    ready = 1'b1;
    step(3);
    chk("t5_beats", beats[0] - b0, 1);
    set_src(0, 3'd4);
    step(25);

    // 6: reset while a command is pending
    ready = 1'b0;
    set_src(0, 3'd3);
    step(9);
    chk("t6_valid_pre", int'(bus0.cmd_valid), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", int'(bus0.cmd_valid), 0);
    chk("t6_rst_dir", int'(bus0.cmd_dir), 0);
    chk("t6_rst_level", int'(lvl0), 4);
    chk("t6_rst_drop", int'(drop0), 0);
    step(1);
    rst = 1'b1;
    ready = 1'b1;
    step(7);
    chk("t6_level_early", int'(lvl0), 4);
    step(1);
    chk("t6_level", int'(lvl0), 3);
    step(1);
    chk("t6_reissue", int'(bus0.cmd_valid), 1);
    set_src(0, 3'd4);
    step(25);

    // random phase
    for (int n = 0; n < 300; n++) begin
      set_src($urandom_range(0, 1), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 19) == 0) src_en = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    src_dir = 6'b100100;
    src_en = 2'b11;
    ready = 1'b1;
    step(40);
    chk("end_queue0", q0.size(), 0);
    chk("end_queue1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
